clk_meas: RTL and testbench

CLK_MEAS -- requirements
Module: clk_meas

---
 rtl/clk_meas_pkg.sv | 10 +
 rtl/sync_2ff.sv | 21 ++
 rtl/clk_meas.sv | 137 +++++++++++++
 tb/tb_clk_meas.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared defaults and FSM encoding for the clk_in period/duty measurement block.
package clk_meas_pkg;
  localparam int CNT_W_DEF  = 8;
  localparam int LOCK_N_DEF = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/clk_meas.sv
// Measures period and high time of an asynchronous clk_in in clk cycles,
// flags lock after LOCK_N identical periods and sticky overflow on a stalled input.
module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       MATCH_TOP = 4'(LOCK_N - 1);

  logic s2, rise;
  state_e state_q, state_d;
  logic s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [3:0] match_q, match_d;
  logic prev_q, prev_d;  // a prior period exists to compare against
  logic mv_q, mv_d, locked_q, locked_d, ovf_q, ovf_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_in),
    .q   (s2)
  );

  assign rise = s2 & ~s3_q;

  always_comb begin
    state_d  = state_q;
    s3_d     = s2;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    match_d  = match_q;
    prev_d   = prev_q;
    mv_d     = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      period_d = '0;
      high_d   = '0;
      match_d  = '0;
      prev_d   = 1'b0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // A rise on the last count still counts as a valid measurement.
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            mv_d     = 1'b1;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
            prev_d   = 1'b1;
            if (prev_q && cnt_q == period_q)
              match_d = (match_q == MATCH_TOP) ? match_q : 4'(match_q + 4'd1);
            else
              match_d = '0;
            locked_d = (match_d == MATCH_TOP);
          end else if (cnt_q == CNT_MAX) begin
            state_d  = ST_IDLE;
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            prev_d   = 1'b0;
            cnt_d    = '0;
            hcnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (s2) hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      match_q  <= '0;
      prev_q   <= 1'b0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      match_q  <= match_d;
      prev_q   <= prev_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: a per-cycle pattern generator drives clk_in on negedges.
module tb_clk_meas;
  logic clk = 1'b0;
  logic rst, en, clk_in;
  logic [7:0] period, high_time;
  logic meas_valid, locked, ovf;
  int checks = 0;
  int errors = 0;
  logic gen_on = 1'b0;
  int gen_hi = 1;
  int gen_lo = 1;

  always #5 clk = ~clk;

  clk_meas #(.CNT_W(8), .LOCK_N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clk_in     (clk_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .ovf        (ovf)
  );

  // New hi/lo take effect only at a period boundary; phase 0 drives high.
  initial begin
    int ph, chi, clo;
    ph = 0; chi = 1; clo = 1;
    clk_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        clk_in = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0) begin chi = gen_hi; clo = gen_lo; end
        clk_in = (ph < chi);
        ph = (ph + 1 == chi + clo) ? 0 : ph + 1;
      end
    end
  end

  // n = negedges waited until meas_valid seen (1-based), -1 on timeout
  task automatic wait_mv(input int budget, output int n);
    bit got;
    got = 0; n = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (meas_valid) got = 1;
    end
    if (!got) n = -1;
  endtask

  task automatic start_gen(input int hi, input int lo);
    @(posedge clk);
    gen_hi = hi; gen_lo = lo; gen_on = 1'b1;
  endtask

  task automatic stop_gen();
    @(posedge clk);
    gen_on = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (period !== 8'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
    checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_time); end
    checks++; if ({meas_valid, locked, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {meas_valid, locked, ovf}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div3();
    int n;
    en = 1'b1;
    repeat (2) @(negedge clk);
    start_gen(2, 1);
    for (int k = 1; k <= 4; k++) begin
      wait_mv(50, n);
      checks++; if (n !== ((k == 1) ? 7 : 3)) begin errors++; $display("FAIL div3_spacing%0d got %0d exp %0d", k, n, (k == 1) ? 7 : 3); end
      checks++; if (period !== 8'd3 || high_time !== 8'd2) begin errors++; $display("FAIL div3_meas%0d got %0d/%0d exp 3/2", k, period, high_time); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL div3_locked%0d got %b exp %b", k, locked, k == 4); end
    end
  endtask

  task automatic test_lock_switch();
    int n;
    int exp_p[5] = '{8, 5, 5, 5, 5};
    int exp_h[5] = '{4, 2, 2, 2, 2};
    bit exp_l[5] = '{1, 0, 0, 0, 1};
    stop_gen();
    en = 1'b0; repeat (2) @(negedge clk); en = 1'b1; repeat (2) @(negedge clk);
    start_gen(4, 4);
    for (int k = 1; k <= 4; k++) begin
      wait_mv(50, n);
      if (k == 1) begin
        checks++; if (n !== 12) begin errors++; $display("FAIL sq8_first_latency got %0d exp 12", n); end
      end
      checks++; if (period !== 8'd8 || high_time !== 8'd4) begin errors++; $display("FAIL sq8_meas%0d got %0d/%0d exp 8/4", k, period, high_time); end
      checks++; if (locked !== (k == 4)) begin errors++; $display("FAIL sq8_locked%0d got %b exp %b", k, locked, k == 4); end
    end
    gen_hi = 2; gen_lo = 3;
    for (int k = 0; k < 5; k++) begin
      wait_mv(50, n);
      checks++; if (n < 0) begin errors++; $display("FAIL sw5_timeout%0d got %0d exp >0", k, n); end
      checks++; if (period !== 8'(exp_p[k]) || high_time !== 8'(exp_h[k])) begin errors++; $display("FAIL sw5_meas%0d got %0d/%0d exp %0d/%0d", k, period, high_time, exp_p[k], exp_h[k]); end
      checks++; if (locked !== exp_l[k]) begin errors++; $display("FAIL sw5_locked%0d got %b exp %b", k, locked, exp_l[k]); end
    end
  endtask

  task automatic test_overflow();
    int n;
    bit got;
    stop_gen();
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ovf) got = 1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", got); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ovf_locked got %b exp 0", locked); end
    checks++; if (period !== 8'd5 || high_time !== 8'd2) begin errors++; $display("FAIL ovf_hold got %0d/%0d exp 5/2", period, high_time); end
    start_gen(4, 4);
    wait_mv(50, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL ovf_rearm_latency got %0d exp 12", n); end
    checks++; if (period !== 8'd8 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got p=%0d ovf=%b exp p=8 ovf=1", period, ovf); end
    wait_mv(50, n);
    checks++; if (ovf !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL ovf_sticky2 got ovf=%b lk=%b exp 1/0", ovf, locked); end
  endtask

  task automatic test_en_clear();
    int n;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++; if ({period, high_time} !== 16'd0) begin errors++; $display("FAIL en_clear_meas got %0d/%0d exp 0/0", period, high_time); end
    checks++; if ({meas_valid, locked, ovf} !== 3'b000) begin errors++; $display("FAIL en_clear_flags got %b exp 000", {meas_valid, locked, ovf}); end
    stop_gen();
    en = 1'b1;
    repeat (2) @(negedge clk);
    start_gen(4, 4);
    wait_mv(50, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL reen_latency got %0d exp 12", n); end
    checks++; if (period !== 8'd8 || high_time !== 8'd4 || ovf !== 1'b0) begin errors++; $display("FAIL reen_meas got %0d/%0d ovf=%b exp 8/4 ovf=0", period, high_time, ovf); end
  endtask

  task automatic test_rst_mid();
    int n;
    for (int k = 0; k < 3; k++) wait_mv(50, n);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL prerst_locked got %b exp 1", locked); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({period, high_time} !== 16'd0 || {meas_valid, locked, ovf} !== 3'b000) begin errors++; $display("FAIL rst_async got %0d/%0d %b exp 0/0 000", period, high_time, {meas_valid, locked, ovf}); end
    stop_gen();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_gen(4, 4);
    wait_mv(50, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL rst_rearm_latency got %0d exp 12", n); end
    checks++; if (period !== 8'd8) begin errors++; $display("FAIL rst_rearm_period got %0d exp 8", period); end
  endtask

  task automatic test_boundary();
    int n;
    bit got_ovf, got_mv;
    stop_gen();
    en = 1'b0; @(negedge clk); en = 1'b1; repeat (2) @(negedge clk);
    start_gen(1, 254);
    wait_mv(300, n);
    checks++; if (n !== 259) begin errors++; $display("FAIL p255_latency got %0d exp 259", n); end
    checks++; if (period !== 8'd255 || high_time !== 8'd1 || ovf !== 1'b0) begin errors++; $display("FAIL p255_meas got %0d/%0d ovf=%b exp 255/1 ovf=0", period, high_time, ovf); end
    stop_gen();
    en = 1'b0; @(negedge clk); en = 1'b1; repeat (2) @(negedge clk);
    start_gen(1, 255);
    got_ovf = 0; got_mv = 0;
    for (int i = 0; i < 400 && !got_ovf; i++) begin
      @(negedge clk);
      if (meas_valid) got_mv = 1;
      if (ovf) got_ovf = 1;
    end
    checks++; if (got_ovf !== 1'b1 || got_mv !== 1'b0) begin errors++; $display("FAIL p256_ovf got ovf=%b mv=%b exp 1/0", got_ovf, got_mv); end
    checks++; if (period !== 8'd0) begin errors++; $display("FAIL p256_period got %0d exp 0", period); end
    en = 1'b0;
    stop_gen();
  endtask

  initial begin
    test_reset();
    test_div3();
    test_lock_switch();
    test_overflow();
    test_en_clear();
    test_rst_mid();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
